// File: rtl/jtsdram_bank_fill.sv
// Fills one SDRAM bank with a 16-bit Galois LFSR pattern via the controller's
// wr/ack/rdy handshake, then replays the same sequence on chk_ref for the read-checker.
module jtsdram_bank_fill #(
    parameter int          AW   = 22,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          LVBL,
    input  logic          start,
    output logic [AW-1:0] addr,
    output logic          wr,
    output logic [15:0]   din,
    input  logic          ack,
    input  logic          rdy,
    output logic          chk_start,
    input  logic          chk_adv,
    output logic [15:0]   chk_ref,
    output logic          busy,
    output logic          done
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DONE} state_t;

    state_t        state_q;
    logic [AW-1:0] addr_q;
    logic          wr_q;
    logic [15:0]   din_q;
    logic [15:0]   chk_ref_q;
    logic          chk_start_q;
    logic          busy_q;
    logic          done_q;
    logic          word_done_d;
    logic          last_word_d;

    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
    endfunction

    // A word completes on rdy while waiting, or when ack and rdy coincide in REQ.
    always_comb begin
        word_done_d = (state_q == WAIT && rdy) || (state_q == REQ && ack && rdy);
        last_word_d = &addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wr_q        <= 1'b0;
            din_q       <= SEED;
            chk_ref_q   <= SEED;
            chk_start_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            chk_start_q <= 1'b0;
            if (chk_adv)
                chk_ref_q <= lfsr_step(chk_ref_q);

            if (start) begin
                state_q <= REQ;
                addr_q  <= '0;
                din_q   <= SEED;
                wr_q    <= 1'b1;
                busy_q  <= 1'b1;
                done_q  <= 1'b0;
            end else if (word_done_d) begin
                wr_q <= 1'b0;
                if (last_word_d) begin
                    // Reload wins over a coincident chk_adv so the checker starts aligned.
                    state_q     <= DONE;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b1;
                    chk_start_q <= 1'b1;
                    chk_ref_q   <= SEED;
                end else begin
                    addr_q  <= addr_q + AW'(1);
                    din_q   <= lfsr_step(din_q);
                    wr_q    <= LVBL;
                    state_q <= LVBL ? REQ : HOLD;
                end
            end else if (state_q == REQ && ack) begin
                wr_q    <= 1'b0;
                state_q <= WAIT;
            end else if (state_q == HOLD && LVBL) begin
                wr_q    <= 1'b1;
                state_q <= REQ;
            end
        end
    end

    assign addr      = addr_q;
    assign wr        = wr_q;
    assign din       = din_q;
    assign chk_ref   = chk_ref_q;
    assign chk_start = chk_start_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_jtsdram_bank_fill.sv
// Bench for jtsdram_bank_fill: scoreboarded write requests, table-driven checker
// reference stepping, LVBL hold, ack/rdy coincidence, restart and reset abort.
`timescale 1ns/1ps
module tb_jtsdram_bank_fill;
    localparam int          AW    = 4;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          LVBL = 1'b1;
    logic          start = 1'b0;
    logic          ack = 1'b0;
    logic          rdy = 1'b0;
    logic          chk_adv = 1'b0;
    logic [AW-1:0] addr;
    logic          wr;
    logic [15:0]   din;
    logic          chk_start;
    logic [15:0]   chk_ref;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    jtsdram_bank_fill #(.AW(AW), .SEED(SEED)) dut (
        .clk(clk), .rst_n(rst_n), .LVBL(LVBL), .start(start),
        .addr(addr), .wr(wr), .din(din), .ack(ack), .rdy(rdy),
        .chk_start(chk_start), .chk_adv(chk_adv), .chk_ref(chk_ref),
        .busy(busy), .done(done)
    );

    typedef struct { logic [AW-1:0] addr; logic [15:0] din; } req_t;
    typedef struct { logic adv; logic [15:0] exp_ref; } vec_t;

    req_t          exp_q[$];
    vec_t          vecs[12];
    logic [15:0]   exp_din[WORDS];
    logic [15:0]   mem[WORDS];
    int            n_chk = 0;
    int            n_fail = 0;
    int            n_chk_start = 0;
    logic          wr_prev = 1'b0;
    logic [AW-1:0] addr_prev = '0;
    logic [15:0]   cur_ref;
    logic          bad;

    function automatic logic [15:0] model_step(input logic [15:0] q);
        logic [15:0] s;
        s = q >> 1;
        if (q[0]) s = s ^ 16'hB400;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fill();
        req_t e;
        for (int i = 0; i < WORDS; i++) begin
            e.addr = AW'(i);
            e.din  = exp_din[i];
            exp_q.push_back(e);
        end
    endtask

    // mode 0: ack at +2, rdy at +4; mode 1: as 0 with LVBL low at rdy; mode 2: ack+rdy together, LVBL low
    task automatic serve_word(input int mode);
        int            cnt;
        logic [AW-1:0] a;
        logic [15:0]   d;
        cnt = 0;
        while (!wr && cnt < 50) begin
            tick();
            cnt++;
        end
        if (!wr) begin
            check("req_timeout", wr, 1);
            return;
        end
        a = addr;
        d = din;
        tick();
        if (mode == 2) begin
            LVBL = 1'b0; ack = 1'b1; rdy = 1'b1;
            tick();
            ack = 1'b0; rdy = 1'b0;
        end else begin
            ack = 1'b1;
            tick();
            ack = 1'b0;
            tick();
            rdy = 1'b1;
            if (mode == 1) LVBL = 1'b0;
            tick();
            rdy = 1'b0;
        end
        mem[a] = d;
    endtask

    // Scoreboard: each newly presented request must match the head of the queue.
    always @(negedge clk) begin : mon
        req_t e;
        if (wr === 1'b1 && (!wr_prev || addr != addr_prev)) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL req_unexpected: addr %0h din %0h with empty queue", addr, din);
            end else begin
                e = exp_q.pop_front();
                check("req_addr", addr, e.addr);
                check("req_din", din, e.din);
            end
        end
        if (chk_start === 1'b1) n_chk_start++;
        wr_prev   = (wr === 1'b1);
        addr_prev = addr;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_din[0] = SEED;
        for (int i = 1; i < WORDS; i++) exp_din[i] = model_step(exp_din[i-1]);
        cur_ref = 16'h7138;
        for (int i = 0; i < 12; i++) begin
            vecs[i].adv = (i % 3 != 2);
            if (vecs[i].adv) cur_ref = model_step(cur_ref);
            vecs[i].exp_ref = cur_ref;
        end

        // Reset state
        repeat (3) tick();
        check("rst_addr", addr, 0);
        check("rst_wr", wr, 0);
        check("rst_din", din, 16'hACE1);
        check("rst_chk_ref", chk_ref, 16'hACE1);
        check("rst_chk_start", chk_start, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        tick();

        // Fill 1: plain fill
        push_fill();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_wr", wr, 1);
        check("start_addr", addr, 0);
        check("start_din", din, 16'hACE1);
        check("start_busy", busy, 1);
        for (int w = 0; w < WORDS; w++) serve_word(0);
        check("fill1_done", done, 1);
        check("fill1_chk_start", chk_start, 1);
        check("fill1_busy", busy, 0);
        check("fill1_wr", wr, 0);
        tick();
        check("fill1_chk_start_drop", chk_start, 0);
        check("fill1_done_hold", done, 1);
        check("fill1_chk_start_count", n_chk_start, 1);
        check("fill1_queue_empty", exp_q.size(), 0);

        // Checker reference stepping
        check("ref0", chk_ref, 16'hACE1);
        chk_adv = 1'b1; tick(); chk_adv = 1'b0;
        check("ref1", chk_ref, 16'hE270);
        chk_adv = 1'b1; tick(); chk_adv = 1'b0;
        check("ref2", chk_ref, 16'h7138);
        for (int i = 0; i < 12; i++) begin
            chk_adv = vecs[i].adv;
            tick();
            chk_adv = 1'b0;
            check($sformatf("ref_vec%0d", i), chk_ref, vecs[i].exp_ref);
        end

        // Fill 2: start with chk_adv, LVBL hold, ack/rdy coincidence, restart at addr 7
        push_fill();
        start = 1'b1; chk_adv = 1'b1;
        tick();
        start = 1'b0; chk_adv = 1'b0;
        check("start_adv_ref", chk_ref, model_step(cur_ref));
        check("start2_done", done, 0);
        check("start2_addr", addr, 0);
        serve_word(0);
        serve_word(0);
        serve_word(1);
        check("hold_wr", wr, 0);
        check("hold_addr", addr, 3);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_wr_stay", wr, 0);
        end
        LVBL = 1'b1;
        tick();
        check("hold_release_wr", wr, 1);
        check("hold_release_addr", addr, 3);
        check("hold_release_din", din, exp_din[3]);
        serve_word(2);
        check("same_wr", wr, 0);
        check("same_addr", addr, 4);
        tick();
        check("same_addr_once", addr, 4);
        LVBL = 1'b1;
        tick();
        check("same_release_wr", wr, 1);
        serve_word(0);
        serve_word(0);
        serve_word(0);
        check("mid_addr7", addr, 7);
        tick();
        exp_q.delete();
        push_fill();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_addr", addr, 0);
        check("restart_din", din, 16'hACE1);
        check("restart_done", done, 0);
        check("restart_wr", wr, 1);
        for (int w = 0; w < WORDS; w++) serve_word(0);
        check("fill2_done", done, 1);
        tick();
        check("fill2_chk_start_count", n_chk_start, 2);
        check("fill2_queue_empty", exp_q.size(), 0);

        // End-to-end checker against the written memory image
        bad = 1'b0;
        for (int a = 0; a < WORDS; a++) begin
            if (chk_ref !== mem[a]) bad = 1'b1;
            check($sformatf("e2e_word%0d", a), chk_ref, mem[a]);
            chk_adv = 1'b1;
            tick();
            chk_adv = 1'b0;
        end
        check("checker_bad", bad, 0);

        // Fill 3: reset abort mid-fill
        push_fill();
        start = 1'b1;
        tick();
        start = 1'b0;
        serve_word(0);
        serve_word(0);
        serve_word(0);
        tick();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("abort_addr", addr, 0);
        check("abort_wr", wr, 0);
        check("abort_din", din, 16'hACE1);
        check("abort_chk_ref", chk_ref, 16'hACE1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_chk_start", chk_start, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_reset_wr", wr, 0);
        check("post_reset_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/jtsdram_bank_fill.md
# jtsdram_bank_fill

Pattern writer and reference generator for one SDRAM bank in the JTSDRAM tester. After `start`, it writes every 16-bit word of the bank with a 16-bit LFSR sequence through the SDRAM controller's request/ack/rdy handshake. Writes are held off while `LVBL` is low. When the fill completes, it pulses `chk_start` to launch the downstream bank read-checker, and it replays the same LFSR sequence on `chk_ref` so the checker can compare each word it reads back.

## Interface
Parameters:
- `AW`, 22, word-address width; the bank holds 2^AW words.
- `SEED`, 16'hACE1, LFSR seed; must be nonzero.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `LVBL`  in  1  vertical blank, active-low; new write requests are issued only while it is high.
- `start`  in  1  one-cycle pulse; begins or restarts a fill.
- `addr`  out  AW  write word address.
- `wr`  out  1  write request to the SDRAM controller.
- `din`  out  16  write data; equals the current fill LFSR value.
- `ack`  in  1  controller accepted the request.
- `rdy`  in  1  controller finished the write.
- `chk_start`  out  1  one-cycle pulse when the fill completes; drives the checker's `start`.
- `chk_adv`  in  1  advance `chk_ref`; wired to the checker's `rdy`.
- `chk_ref`  out  16  reference word for the checker's `data_ref`.
- `busy`  out  1  high while a fill is in progress.
- `done`  out  1  high once the fill completes; cleared by `start`.

## Operation
- LFSR step, shared by both generators: 16-bit Galois, `next = {1'b0,q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0)`.
- States:
  - IDLE: nothing issued.
  - REQ: `wr` high, waiting for `ack`.
  - WAIT: waiting for `rdy`.
  - HOLD: the word is done but `LVBL` is low, so the next request is deferred.
  - DONE: fill finished.
- `start`, from any state: `addr`=0, fill LFSR=`SEED`, `done`=0, `busy`=1, next state REQ.
- REQ, on `ack`: `wr`=0, next state WAIT.
- `ack` and `rdy` in the same cycle: `wr`=0 and the word is completed in that cycle.
- On `rdy` in WAIT (or in REQ together with `ack`):
  - If `addr` is all ones: `busy`=0, `done`=1, `chk_start` pulses for 1 cycle, `chk_ref` reloads to `SEED`, next state DONE.
  - Otherwise: `addr`+1, fill LFSR steps. Next state is REQ with `wr`=1 if `LVBL` is 1, else HOLD with `wr`=0.
- HOLD: stays until `LVBL` is 1, then `wr`=1 and next state REQ.
- `rdy` outside WAIT/REQ: ignored. `ack` outside REQ: ignored.
- `addr` never wraps during a fill; completing the last word ends it.
- Checker side: `chk_ref` steps once on each `chk_adv`. `chk_adv` is honoured in every state, including during a later fill.
- `start` and `chk_adv` in the same cycle: `start` wins for the fill state; `chk_ref` still steps.
- Asserting `rst_n` at any time aborts everything. No partial-fill state survives.

## Timing
- Reset values: `addr`=0, `wr`=0, `din`=`SEED`, `chk_ref`=`SEED`, `chk_start`=0, `busy`=0, `done`=0, state IDLE.
- Registered outputs. `din` is valid whenever `wr` is high and stays stable until the next `rdy`.
- `start` at edge t: `wr`=1, `addr`=0, `din`=`SEED` at t+1.
- `rdy` at edge t with `LVBL`=1: next request (`wr`=1, new `addr`/`din`) at t+1.
- `LVBL` rises at edge t while in HOLD: `wr`=1 at t+1.
- Last `rdy` at edge t: `chk_start`=1 and `done`=1 at t+1; `chk_start`=0 at t+2.
- `chk_adv` at edge t: new `chk_ref` visible at t+1. The checker samples the old value at t.

## Test plan
- Reset, then `start` with AW=4, SEED=16'hACE1, `LVBL`=1, and a controller giving `ack` at +2 and `rdy` at +4 -> `din` sequence ACE1, E270, 7138, … for 16 words; `addr` 0..15; `done`=1 and a single `chk_start` after word 15.
- After the fill, pulse `chk_adv` twice -> `chk_ref` goes ACE1 -> E270 -> 7138. Connect the checker end-to-end -> the checker's `bad` stays 0.
- Hold `LVBL`=0 across a `rdy` -> `wr` stays 0 in HOLD; `LVBL`=1 -> `wr`=1 next cycle with the next `addr`/`din`.
- Give `ack` and `rdy` in the same cycle -> `wr` drops and `addr` advances exactly once.
- `start` mid-fill at `addr`=7 -> next cycle `addr`=0, `din`=ACE1, `done`=0; assert `rst_n`=0 mid-fill -> all outputs return to their reset values immediately.
